// File: rtl/sprite_pkg.sv
// Shared sprite constants: default geometry, FSM states and the 16x16 ship bitmap.
// Bitmap rows are MSB-first: bit 15 is the leftmost column.
package sprite_pkg;

   localparam int SPR_W_DEF = 16;
   localparam int SPR_H_DEF = 16;
   localparam int BMP_W     = 16;
   localparam int BMP_H     = 16;
   localparam int BMP_RW    = 4;

   typedef enum logic [1:0] {IDLE, ARMED, DRAW} state_t;

   // Row 15 first so that SHIP[r] selects bitmap row r.
   localparam logic [BMP_H-1:0][BMP_W-1:0] SHIP = {
      16'h0100, 16'h0300, 16'h0780, 16'h0FC0,
      16'h1FF0, 16'h3FFC, 16'h3FFE, 16'h3E7F,
      16'h3E7F, 16'h3FFE, 16'h3FFC, 16'h1FF0,
      16'h0FC0, 16'h0780, 16'h0300, 16'h0000
   };

   // Exhaust flame: columns 0-1 of rows 5-10, inverted in every frame except frame 0.
   localparam logic [BMP_W-1:0]  FLAME_MASK   = 16'hC000;
   localparam logic [BMP_RW-1:0] FLAME_ROW_LO = 4'd5;
   localparam logic [BMP_RW-1:0] FLAME_ROW_HI = 4'd10;

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite bitmap lookup: one SPR_W-bit row of the selected animation frame.
module sprite_rom
   import sprite_pkg::*;
#(
   parameter int SPR_W   = SPR_W_DEF,
   parameter int SPR_H   = SPR_H_DEF,
   parameter int FRAME_W = 2,
   parameter int ROW_W   = 4
) (
   input  logic [FRAME_W-1:0] frame,
   input  logic [ROW_W-1:0]   row,
   output logic [SPR_W-1:0]   bits
);

   logic [BMP_RW-1:0] ri;
   logic [BMP_W-1:0]  base;

   always_comb begin
      ri   = BMP_RW'(row);
      base = SHIP[ri];
      if ((frame != '0) && (ri >= FLAME_ROW_LO) && (ri <= FLAME_ROW_HI))
         base = base ^ FLAME_MASK;
   end

   // Sprites wider than the bitmap repeat it horizontally.
   for (genvar c = 0; c < SPR_W; c++) begin : g_col
      assign bits[SPR_W-1-c] = base[BMP_W-1-(c % BMP_W)];
   end

endmodule

// File: rtl/sprite_engine.sv
// Single hardware sprite: per-frame shadowed position/flags, animation ticker and
// a per-line IDLE/ARMED/DRAW sequencer emitting one registered pixel per clock.
module sprite_engine
   import sprite_pkg::*;
#(
   parameter int SPR_W    = SPR_W_DEF,
   parameter int SPR_H    = SPR_H_DEF,
   parameter int N_FRAMES = 4,
   parameter int COORD_W  = 10,
   localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] hcount,
   input  logic [COORD_W-1:0] vcount,
   input  logic               line_start,
   input  logic               frame_start,
   input  logic [COORD_W-1:0] spr_x,
   input  logic [COORD_W-1:0] spr_y,
   input  logic               visible,
   input  logic               flip_x,
   input  logic               flip_y,
   input  logic [3:0]         anim_rate,
   output logic               pixel_on,
   output logic [FRAME_W-1:0] frame_idx,
   output logic               drawing
);

   localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam logic [COORD_W:0]  H_LIM   = (COORD_W+1)'(SPR_H);
   localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(SPR_H - 1);
   localparam logic [COL_W-1:0]  COL_MAX = COL_W'(SPR_W - 1);

   state_t             state, state_nxt;
   logic [COORD_W-1:0] x0, y0;
   logic               vis, fx, fy;
   logic [3:0]         tick, tick_nxt;
   logic [FRAME_W-1:0] frame_nxt;
   logic [SPR_W-1:0]   line_bits, line_nxt, rom_bits;
   logic [COL_W-1:0]   col, col_nxt;
   logic               pix_nxt;

   logic [COORD_W-1:0] eff_x0, eff_y0;
   logic               eff_vis, eff_fx, eff_fy, row_hit;
   logic [COORD_W:0]   row_diff;
   logic [ROW_W-1:0]   rom_row;

   function automatic logic pick(input logic [SPR_W-1:0] b, input logic [COL_W-1:0] c,
                                 input logic mirror);
      return mirror ? b[c] : b[COL_MAX - c];
   endfunction

   // A frame_start coinciding with line_start must already see the new shadows and frame.
   always_comb begin
      eff_x0  = frame_start ? spr_x     : x0;
      eff_y0  = frame_start ? spr_y     : y0;
      eff_vis = frame_start ? visible   : vis;
      eff_fx  = frame_start ? flip_x    : fx;
      eff_fy  = frame_start ? flip_y    : fy;

      tick_nxt  = tick;
      frame_nxt = frame_idx;
      if (frame_start && (anim_rate != 4'd0)) begin
         if (tick >= anim_rate - 4'd1) begin
            tick_nxt  = 4'd0;
            frame_nxt = (N_FRAMES > 1) ? frame_idx + 1'b1 : '0;
         end else begin
            tick_nxt = tick + 4'd1;
         end
      end

      // The extra sign bit keeps lines above the sprite from wrapping into range.
      row_diff = {1'b0, vcount} - {1'b0, eff_y0};
      row_hit  = eff_vis && !row_diff[COORD_W] && (row_diff < H_LIM);
      rom_row  = row_diff[ROW_W-1:0];
      if (eff_fy)
         rom_row = ROW_MAX - rom_row;
   end

   sprite_rom #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .FRAME_W (FRAME_W),
      .ROW_W   (ROW_W)
   ) u_rom (
      .frame (frame_nxt),
      .row   (rom_row),
      .bits  (rom_bits)
   );

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      line_nxt  = line_bits;
      pix_nxt   = 1'b0;
      if (line_start) begin
         col_nxt = '0;
         if (!row_hit) begin
            state_nxt = IDLE;
         end else begin
            line_nxt = rom_bits;
            // A sprite at x0 == 0 starts in the line_start cycle itself.
            if (hcount == eff_x0) begin
               state_nxt = DRAW;
               pix_nxt   = pick(rom_bits, '0, eff_fx);
            end else begin
               state_nxt = ARMED;
            end
         end
      end else begin
         unique case (state)
            ARMED: begin
               if (hcount == x0) begin
                  state_nxt = DRAW;
                  col_nxt   = '0;
                  pix_nxt   = pick(line_bits, '0, fx);
               end
            end
            DRAW: begin
               if (col == COL_MAX) begin
                  state_nxt = IDLE;
               end else begin
                  col_nxt = col + 1'b1;
                  pix_nxt = pick(line_bits, COL_W'(col + 1'b1), fx);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= '0;
         line_bits <= '0;
         pixel_on  <= 1'b0;
         tick      <= 4'd0;
         frame_idx <= '0;
         x0        <= '0;
         y0        <= '0;
         vis       <= 1'b0;
         fx        <= 1'b0;
         fy        <= 1'b0;
      end else begin
         state     <= state_nxt;
         col       <= col_nxt;
         line_bits <= line_nxt;
         pixel_on  <= pix_nxt;
         tick      <= tick_nxt;
         frame_idx <= frame_nxt;
         if (frame_start) begin
            x0  <= spr_x;
            y0  <= spr_y;
            vis <= visible;
            fx  <= flip_x;
            fy  <= flip_y;
         end
      end
   end

   assign drawing = (state == DRAW);

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: animation vector table, directed raster
// sequences and randomized frames compared against a pixel-level reference model.
module tb_sprite_engine;

   localparam int SPR_W    = 16;
   localparam int SPR_H    = 16;
   localparam int N_FRAMES = 4;
   localparam int COORD_W  = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [9:0]   hcount = '0, vcount = '0, spr_x = '0, spr_y = '0;
   logic         line_start = 1'b0, frame_start = 1'b0;
   logic         visible = 1'b0, flip_x = 1'b0, flip_y = 1'b0;
   logic [3:0]   anim_rate = '0;
   logic         pixel_on, drawing;
   logic [1:0]   frame_idx;

   sprite_engine #(
      .SPR_W    (SPR_W),
      .SPR_H    (SPR_H),
      .N_FRAMES (N_FRAMES),
      .COORD_W  (COORD_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hcount      (hcount),
      .vcount      (vcount),
      .line_start  (line_start),
      .frame_start (frame_start),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .visible     (visible),
      .flip_x      (flip_x),
      .flip_y      (flip_y),
      .anim_rate   (anim_rate),
      .pixel_on    (pixel_on),
      .frame_idx   (frame_idx),
      .drawing     (drawing)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Reference copy of the ship, row 0 first, MSB = leftmost column.
   logic [15:0] ship [16] = '{
      16'h0000, 16'h0300, 16'h0780, 16'h0FC0, 16'h1FF0, 16'h3FFC, 16'h3FFE, 16'h3E7F,
      16'h3E7F, 16'h3FFE, 16'h3FFC, 16'h1FF0, 16'h0FC0, 16'h0780, 16'h0300, 16'h0100
   };

   // Model: frame-level shadows plus the line latched at line_start.
   int m_x0, m_y0, m_rate, m_pulses;
   bit m_vis, m_fx, m_fy;
   bit l_valid, l_fx;
   int l_row, l_frame, l_x0;

   bit cap_pix [1024];
   bit cap_drw [1024];

   typedef struct {
      bit         fs;
      logic [3:0] rate;
      int         exp_frame;
   } anim_vec_t;

   anim_vec_t avec [12];

   function automatic int modelFrame();
      return (m_rate == 0) ? 0 : (m_pulses / m_rate) % N_FRAMES;
   endfunction

   function automatic bit shipPixel(int f, int r, int c);
      bit b;
      b = ship[r][15-c];
      if (f != 0 && r >= 5 && r <= 10 && c < 2)
         b = ~b;
      return b;
   endfunction

   function automatic bit expDrawing(int h);
      int c;
      c = h - l_x0;
      return l_valid && c >= 0 && c < SPR_W;
   endfunction

   function automatic bit expPixel(int h);
      int c;
      c = h - l_x0;
      if (!expDrawing(h))
         return 1'b0;
      return shipPixel(l_frame, l_row, l_fx ? SPR_W-1-c : c);
   endfunction

   function automatic logic [15:0] packWin(int x, int n);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < n; i++)
         r = {r[14:0], cap_pix[x+i]};
      return r;
   endfunction

   function automatic int onesIn(int lo, int hi);
      int n;
      n = 0;
      for (int i = lo; i <= hi; i++)
         n += int'(cap_pix[i]);
      return n;
   endfunction

   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got == exp)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
   endtask

   task automatic resetDut();
      rst_n       = 1'b0;
      line_start  = 1'b0;
      frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset pixel_on", int'(pixel_on), 0);
      checkOutput("reset drawing", int'(drawing), 0);
      checkOutput("reset frame_idx", int'(frame_idx), 0);
      rst_n    = 1'b1;
      m_x0     = 0;
      m_y0     = 0;
      m_vis    = 1'b0;
      m_fx     = 1'b0;
      m_fy     = 1'b0;
      m_pulses = 0;
   endtask

   // One raster line: line_start at hcount 0, optional frame_start with it.
   task automatic applyStimulus(input int v, input int len, input bit fs);
      int r, bad, first;
      vcount = 10'(v);
      if (fs) begin
         m_x0  = int'(spr_x);
         m_y0  = int'(spr_y);
         m_vis = visible;
         m_fx  = flip_x;
         m_fy  = flip_y;
         m_pulses++;
      end
      r       = v - m_y0;
      l_valid = m_vis && r >= 0 && r < SPR_H;
      l_row   = m_fy ? SPR_H-1-r : r;
      l_frame = modelFrame();
      l_fx    = m_fx;
      l_x0    = m_x0;
      bad     = 0;
      first   = -1;
      for (int h = 0; h < len; h++) begin
         hcount      = 10'(h);
         line_start  = (h == 0);
         frame_start = fs && (h == 0);
         @(posedge clk);
         #1;
         cap_pix[h] = pixel_on;
         cap_drw[h] = drawing;
         if (pixel_on !== expPixel(h) || drawing !== expDrawing(h)) begin
            bad++;
            if (first < 0)
               first = h;
         end
      end
      line_start  = 1'b0;
      frame_start = 1'b0;
      checkOutput($sformatf("line %0d pixel/drawing mismatches (first at h=%0d)", v, first),
                  bad, 0);
   endtask

   task automatic randomizeSprite();
      spr_x   = 10'($urandom_range(0, 159));
      spr_y   = 10'($urandom_range(0, 23));
      visible = ($urandom_range(0, 4) != 0);
      flip_x  = 1'($urandom_range(0, 1));
      flip_y  = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int nhigh;
      m_rate = 0;

      avec[0]  = '{1'b0, 4'd2, 0};
      avec[1]  = '{1'b1, 4'd2, 0};
      avec[2]  = '{1'b1, 4'd2, 1};
      avec[3]  = '{1'b1, 4'd2, 1};
      avec[4]  = '{1'b1, 4'd2, 2};
      avec[5]  = '{1'b1, 4'd2, 2};
      avec[6]  = '{1'b1, 4'd0, 2};
      avec[7]  = '{1'b1, 4'd0, 2};
      avec[8]  = '{1'b1, 4'd2, 3};
      avec[9]  = '{1'b1, 4'd1, 0};
      avec[10] = '{1'b1, 4'd1, 1};
      avec[11] = '{1'b0, 4'd1, 1};

      resetDut();
      for (int i = 0; i < 12; i++) begin
         anim_rate   = avec[i].rate;
         frame_start = avec[i].fs;
         @(posedge clk);
         #1;
         frame_start = 1'b0;
         checkOutput($sformatf("anim vector %0d frame_idx", i), int'(frame_idx),
                     avec[i].exp_frame);
      end

      // Basic placement, row 2 on line 52.
      resetDut();
      m_rate    = 0;
      anim_rate = 4'd0;
      spr_x = 10'd100; spr_y = 10'd50; visible = 1'b1; flip_x = 1'b0; flip_y = 1'b0;
      applyStimulus(0, 160, 1'b1);
      applyStimulus(52, 160, 1'b0);
      checkOutput("line 52 row-2 window", int'(packWin(100, 16)), 16'h0780);
      checkOutput("line 52 pixels outside window", onesIn(0, 99) + onesIn(116, 159), 0);
      checkOutput("line 52 drawing before x0", int'(cap_drw[99]), 0);
      checkOutput("line 52 drawing at x0", int'(cap_drw[100]), 1);
      checkOutput("line 52 drawing after last column", int'(cap_drw[116]), 0);

      // Mid-frame spr_y change must not take effect until the next frame_start.
      spr_y = 10'd0;
      applyStimulus(52, 160, 1'b0);
      checkOutput("shadowed y: line 52 still row 2", int'(packWin(100, 16)), 16'h0780);
      applyStimulus(5, 160, 1'b0);
      checkOutput("shadowed y: line 5 empty", onesIn(0, 159), 0);
      applyStimulus(0, 160, 1'b1);
      applyStimulus(5, 160, 1'b0);
      checkOutput("new y: line 5 row 5", int'(packWin(100, 16)), 16'h3FFC);

      // Both mirrors: line 50 shows row 15 reversed.
      spr_y = 10'd50; flip_x = 1'b1; flip_y = 1'b1;
      applyStimulus(0, 160, 1'b1);
      applyStimulus(50, 160, 1'b0);
      checkOutput("flipped line 50", int'(packWin(100, 16)), 16'h0080);

      // Right-edge clipping on a 640-pixel line.
      flip_x = 1'b0; flip_y = 1'b0; spr_x = 10'd630;
      applyStimulus(0, 640, 1'b1);
      applyStimulus(55, 640, 1'b0);
      checkOutput("clip line 55 drawing at last pixel", int'(cap_drw[639]), 1);
      checkOutput("clip line 55 visible columns", int'(packWin(630, 10)), 10'h0FF);
      applyStimulus(56, 640, 1'b0);
      checkOutput("clip line 56 drawing dropped on line_start", int'(cap_drw[0]), 0);
      checkOutput("clip line 56 pixels before x0", onesIn(0, 629), 0);

      // Bottom of the coordinate space: no wrap to the top.
      spr_x = 10'd100; spr_y = 10'd1020;
      applyStimulus(0, 160, 1'b1);
      applyStimulus(2, 160, 1'b0);
      checkOutput("no wrap line 2", onesIn(0, 159), 0);
      applyStimulus(1023, 160, 1'b0);
      checkOutput("line 1023 row 3", int'(packWin(100, 16)), 16'h0FC0);

      // Reset asserted while drawing, released mid-line.
      spr_y = 10'd50;
      applyStimulus(0, 160, 1'b1);
      vcount = 10'd52;
      for (int h = 0; h <= 105; h++) begin
         hcount     = 10'(h);
         line_start = (h == 0);
         @(posedge clk);
         #1;
      end
      line_start = 1'b0;
      checkOutput("pre-reset drawing", int'(drawing), 1);
      checkOutput("pre-reset pixel_on", int'(pixel_on), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset pixel_on", int'(pixel_on), 0);
      checkOutput("async reset drawing", int'(drawing), 0);
      nhigh = 0;
      for (int h = 106; h < 160; h++) begin
         hcount = 10'(h);
         if (h == 110)
            rst_n = 1'b1;
         @(posedge clk);
         #1;
         nhigh += int'(pixel_on) + int'(drawing);
      end
      checkOutput("post-reset rest of line quiet", nhigh, 0);
      m_x0 = 0; m_y0 = 0; m_vis = 1'b0; m_fx = 1'b0; m_fy = 1'b0; m_pulses = 0;
      applyStimulus(53, 160, 1'b0);
      checkOutput("post-reset line 53 quiet", onesIn(0, 159), 0);
      applyStimulus(0, 160, 1'b1);
      applyStimulus(52, 160, 1'b0);
      checkOutput("after frame_start line 52 row 2", int'(packWin(100, 16)), 16'h0780);

      // Randomized frames against the model.
      for (int s = 0; s < 2; s++) begin
         resetDut();
         m_rate    = (s == 0) ? 1 : int'($urandom_range(0, 3));
         anim_rate = 4'(m_rate);
         for (int f = 0; f < 5; f++) begin
            randomizeSprite();
            if (f == 1)
               spr_x = 10'd0;
            for (int v = 0; v < 24; v++) begin
               if (v == 12)
                  randomizeSprite();
               applyStimulus(v, 160, v == 0);
               if (v == 0)
                  checkOutput($sformatf("random seg %0d frame %0d frame_idx", s, f),
                              int'(frame_idx), modelFrame());
            end
         end
      end

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
